// File: rtl/mem_arbiter.sv
// Shares one pipelined main memory between the I-cache and D-cache: block fills
// issue one read per cycle, write-through stores go out immediately when idle.
module mem_arbiter #(
  parameter int unsigned BLOCK_WORDS = 8,
  localparam int unsigned OW = $clog2(BLOCK_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          icache_miss,
  input  logic [15:0]   icache_addr,
  input  logic          dcache_miss,
  input  logic [15:0]   dcache_addr,
  input  logic          dcache_wr,
  input  logic [15:0]   dcache_wdata,
  input  logic [15:0]   mem_data_out,
  input  logic          mem_data_valid,
  output logic [15:0]   mem_addr,
  output logic          mem_enable,
  output logic          mem_wr,
  output logic [15:0]   mem_data_in,
  output logic [15:0]   fill_data,
  output logic [OW-1:0] fill_offset,
  output logic          icache_fill_we,
  output logic          dcache_fill_we,
  output logic          icache_done,
  output logic          dcache_done,
  output logic          icache_stall,
  output logic          dcache_stall,
  output logic          busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IFILL = 2'd1;
  localparam logic [1:0] DFILL = 2'd2;

  localparam logic [OW:0]   BW        = (OW+1)'(BLOCK_WORDS);
  localparam logic [OW:0]   ISSUE_ONE = (OW+1)'(1);
  localparam logic [OW-1:0] RECV_ONE  = OW'(1);
  localparam logic [OW-1:0] RECV_LAST = OW'(BLOCK_WORDS - 1);
  localparam logic [15:0]   BASE_MASK = ~((16'd1 << (OW+1)) - 16'd1);

  logic [1:0]    state;
  logic [15:0]   base;
  logic [OW:0]   issue_cnt;
  logic [OW-1:0] recv_cnt;

  logic in_fill, issuing, store_go, fill_we, done;
  logic start_d, start_i;

  assign in_fill  = (state != IDLE);
  assign issuing  = in_fill && (issue_cnt < BW);
  // Gated by rst_n so a store held across reset cannot reach memory.
  assign store_go = rst_n && (state == IDLE) && dcache_wr;
  assign fill_we  = in_fill && mem_data_valid;
  assign done     = fill_we && (recv_cnt == RECV_LAST);

  always_comb begin
    start_d = 1'b0;
    start_i = 1'b0;
    if (state == IDLE) begin
      start_d = dcache_miss;
      start_i = !dcache_miss && icache_miss;
    end else if (done) begin
      // Only the other cache's pending miss is taken at the leaving edge;
      // the finishing cache's miss is still high but already satisfied.
      start_d = (state == IFILL) && dcache_miss;
      start_i = (state == DFILL) && icache_miss;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else if (start_d || start_i) begin
      state     <= start_d ? DFILL : IFILL;
      base      <= (start_d ? dcache_addr : icache_addr) & BASE_MASK;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else if (done) begin
      state <= IDLE;
    end else begin
      if (issuing) issue_cnt <= issue_cnt + ISSUE_ONE;
      if (fill_we) recv_cnt  <= recv_cnt + RECV_ONE;
    end
  end

  always_comb begin
    mem_addr = '0;
    if (issuing)       mem_addr = base | 16'({issue_cnt, 1'b0});
    else if (store_go) mem_addr = dcache_addr;
  end

  assign mem_enable     = issuing || store_go;
  assign mem_wr         = store_go;
  assign mem_data_in    = store_go ? dcache_wdata : '0;
  assign fill_data      = fill_we ? mem_data_out : '0;
  assign fill_offset    = recv_cnt;
  assign icache_fill_we = fill_we && (state == IFILL);
  assign dcache_fill_we = fill_we && (state == DFILL);
  assign icache_done    = done && (state == IFILL);
  assign dcache_done    = done && (state == DFILL);
  assign icache_stall   = icache_miss && !icache_done;
  assign dcache_stall   = (dcache_miss && !dcache_done) || (dcache_wr && in_fill);
  assign busy           = in_fill;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: pipelined memory model with fixed latency, scoreboard
// queues of expected reads, writes and fill words filled in as requests are raised.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk, rst_n;
  logic        icache_miss, dcache_miss, dcache_wr;
  logic [15:0] icache_addr, dcache_addr, dcache_wdata;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic [15:0] mem_addr, mem_data_in, fill_data;
  logic        mem_enable, mem_wr;
  logic [2:0]  fill_offset;
  logic        icache_fill_we, dcache_fill_we, icache_done, dcache_done;
  logic        icache_stall, dcache_stall, busy;

  mem_arbiter #(.BLOCK_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .dcache_wr(dcache_wr), .dcache_wdata(dcache_wdata),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_data_in(mem_data_in), .fill_data(fill_data), .fill_offset(fill_offset),
    .icache_fill_we(icache_fill_we), .dcache_fill_we(dcache_fill_we),
    .icache_done(icache_done), .dcache_done(dcache_done),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Memory model: a read issued in cycle c returns in cycle c+LAT.
  logic        pv [LAT];
  logic [15:0] pa [LAT];
  always @(posedge clk) begin
    pv[0] <= (mem_enable === 1'b1) && (mem_wr === 1'b0);
    pa[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign mem_data_valid = (pv[LAT-1] === 1'b1);
  assign mem_data_out   = mdata(pa[LAT-1]);

  typedef struct packed {
    logic        dside;
    logic [2:0]  off;
    logic [15:0] data;
  } fill_t;

  logic [15:0] exp_rd[$];
  logic [31:0] exp_wr[$];
  fill_t       exp_fill[$];

  int checks = 0;
  int fails  = 0;

  logic        s_en, s_wr, s_ifwe, s_dfwe, s_idone, s_ddone, s_istall, s_dstall, s_busy;
  logic [15:0] s_addr, s_wdata, s_fdata;
  logic [2:0]  s_off;

  task automatic push_block(input logic dside, input logic [15:0] addr,
                            input int nrd, input int nfill);
    logic [15:0] b;
    fill_t f;
    b = addr & 16'hFFF0;
    for (int i = 0; i < nrd; i++) exp_rd.push_back(b + 16'(2 * i));
    for (int i = 0; i < nfill; i++) begin
      f.dside = dside;
      f.off   = 3'(i);
      f.data  = mdata(b + 16'(2 * i));
      exp_fill.push_back(f);
    end
  endtask

  // Samples this cycle's outputs on the falling edge, settles the scoreboard,
  // then steps past the next rising edge.
  task automatic tick;
    logic [15:0] ea;
    logic [31:0] ew;
    fill_t f;
    logic [1:0] exp_sel;
    logic [22:0] got_v, exp_v;
    @(negedge clk);
    s_en = mem_enable; s_wr = mem_wr; s_addr = mem_addr; s_wdata = mem_data_in;
    s_ifwe = icache_fill_we; s_dfwe = dcache_fill_we; s_off = fill_offset;
    s_fdata = fill_data; s_idone = icache_done; s_ddone = dcache_done;
    s_istall = icache_stall; s_dstall = dcache_stall; s_busy = busy;
    if (s_en && !s_wr) begin
      checks++;
      if (exp_rd.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: got read addr %h, required no read", s_addr);
      end else begin
        ea = exp_rd.pop_front();
        if (s_addr !== ea) begin
          fails++;
          $display("FAIL rd_addr: got %h required %h", s_addr, ea);
        end
      end
    end
    if (s_en && s_wr) begin
      checks++;
      if (exp_wr.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: got write addr %h data %h, required none", s_addr, s_wdata);
      end else begin
        ew = exp_wr.pop_front();
        if ({s_addr, s_wdata} !== ew) begin
          fails++;
          $display("FAIL wr_addr_data: got %h required %h", {s_addr, s_wdata}, ew);
        end
      end
    end
    checks++;
    if (s_ifwe || s_dfwe) begin
      if (exp_fill.size() == 0) begin
        fails++;
        $display("FAIL fill_unexpected: got ifwe=%b dfwe=%b off=%0d, required none",
                 s_ifwe, s_dfwe, s_off);
      end else begin
        f = exp_fill.pop_front();
        exp_sel = f.dside ? 2'b01 : 2'b10;
        got_v = {s_ifwe, s_dfwe, s_off, s_fdata, s_idone, s_ddone};
        exp_v = {exp_sel, f.off, f.data, (f.off == 3'd7) ? exp_sel : 2'b00};
        if (got_v !== exp_v) begin
          fails++;
          $display("FAIL fill_word: got {we,off,data,done}=%h required %h", got_v, exp_v);
        end
      end
    end else if ({s_idone, s_ddone} !== 2'b00) begin
      fails++;
      $display("FAIL done_without_fill: got idone=%b ddone=%b required 0", s_idone, s_ddone);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_queues_empty(input string name);
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0 || exp_fill.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got rd=%0d wr=%0d fill=%0d pending, required 0",
               name, exp_rd.size(), exp_wr.size(), exp_fill.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; icache_miss = 1'b1; dcache_miss = 1'b0; dcache_wr = 1'b1;
    icache_addr = 16'h0100; dcache_addr = 16'h1111; dcache_wdata = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({s_busy, s_en, s_wr, s_addr, s_ifwe, s_dfwe, s_idone, s_ddone, s_istall, s_dstall}
          !== {3'b000, 16'h0000, 4'b0000, 2'b10}) begin
        fails++;
        $display("FAIL reset_outputs: got busy=%b en=%b wr=%b addr=%h we=%b%b done=%b%b stall=%b%b",
                 s_busy, s_en, s_wr, s_addr, s_ifwe, s_dfwe, s_idone, s_ddone, s_istall, s_dstall);
      end
    end
    icache_miss = 1'b0; dcache_wr = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({s_busy, s_en} !== 2'b00) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b en=%b required 00", s_busy, s_en);
    end
  endtask

  task automatic test_imiss;
    int first_rd, last_rd, done_c, ndone, xdone, stall_bad, dfwe_n;
    first_rd = -1; last_rd = -1; done_c = -1; ndone = 0; xdone = 0; stall_bad = 0; dfwe_n = 0;
    icache_addr = 16'h1234; icache_miss = 1'b1;
    push_block(1'b0, 16'h1234, 8, 8);
    for (int c = 0; c < 40 && ndone == 0; c++) begin
      tick();
      if (s_en && !s_wr) begin
        if (first_rd < 0) first_rd = c;
        last_rd = c;
      end
      if (s_idone) begin ndone++; done_c = c; end
      if (!s_idone && !s_istall) stall_bad++;
      if (s_dfwe) dfwe_n++;
    end
    icache_miss = 1'b0;
    tick();
    checks++;
    if (s_busy !== 1'b0) begin
      fails++;
      $display("FAIL imiss_idle_after: got busy=%b required 0", s_busy);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (s_idone) xdone++;
    end
    checks++;
    if (first_rd != 1 || last_rd != 8) begin
      fails++;
      $display("FAIL imiss_issue_window: got cycles %0d..%0d required 1..8", first_rd, last_rd);
    end
    checks++;
    if (done_c != 8 + LAT || ndone + xdone != 1) begin
      fails++;
      $display("FAIL imiss_done: got cycle %0d count %0d required cycle %0d count 1",
               done_c, ndone + xdone, 8 + LAT);
    end
    checks++;
    if (stall_bad != 0 || dfwe_n != 0) begin
      fails++;
      $display("FAIL imiss_stall_dfwe: got stall-low %0d dfwe %0d required 0 0", stall_bad, dfwe_n);
    end
    check_queues_empty("imiss");
  endtask

  task automatic test_simultaneous;
    int dd_c, id_c, istall_bad;
    dd_c = -1; id_c = -1; istall_bad = 0;
    icache_addr = 16'h0040; dcache_addr = 16'h8008;
    icache_miss = 1'b1; dcache_miss = 1'b1;
    push_block(1'b1, 16'h8008, 8, 8);
    push_block(1'b0, 16'h0040, 8, 8);
    for (int c = 0; c < 60 && id_c < 0; c++) begin
      tick();
      if (s_ddone) begin dd_c = c; dcache_miss = 1'b0; end
      if (s_idone) id_c = c;
      else if (!s_istall) istall_bad++;
    end
    icache_miss = 1'b0; dcache_miss = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (dd_c != 8 + LAT || id_c != 16 + 2 * LAT) begin
      fails++;
      $display("FAIL simul_order: got ddone@%0d idone@%0d required %0d %0d",
               dd_c, id_c, 8 + LAT, 16 + 2 * LAT);
    end
    checks++;
    if (istall_bad != 0) begin
      fails++;
      $display("FAIL simul_istall: got %0d low cycles required 0", istall_bad);
    end
    check_queues_empty("simul");
  endtask

  task automatic test_store_during_fill;
    int id_c, dstall_bad, wr_early;
    id_c = -1; dstall_bad = 0; wr_early = 0;
    icache_addr = 16'h0100; icache_miss = 1'b1;
    push_block(1'b0, 16'h0100, 8, 8);
    for (int c = 0; c < 3; c++) tick();
    dcache_wr = 1'b1; dcache_addr = 16'h2002; dcache_wdata = 16'hBEEF;
    exp_wr.push_back({16'h2002, 16'hBEEF});
    for (int c = 3; c < 40 && id_c < 0; c++) begin
      tick();
      if (!s_dstall) dstall_bad++;
      if (s_en && s_wr) wr_early++;
      if (s_idone) id_c = c;
    end
    icache_miss = 1'b0;
    tick();
    checks++;
    if ({s_en, s_wr, s_dstall} !== 3'b110) begin
      fails++;
      $display("FAIL store_after_fill: got en,wr,dstall=%b%b%b required 110", s_en, s_wr, s_dstall);
    end
    dcache_wr = 1'b0;
    tick();
    checks++;
    if (id_c != 8 + LAT || dstall_bad != 0 || wr_early != 0) begin
      fails++;
      $display("FAIL store_held: got idone@%0d stall-low %0d early-wr %0d required %0d 0 0",
               id_c, dstall_bad, wr_early, 8 + LAT);
    end
    check_queues_empty("store_fill");
  endtask

  task automatic test_store_and_miss;
    int id_c;
    id_c = -1;
    dcache_wr = 1'b1; dcache_addr = 16'h3004; dcache_wdata = 16'h1357;
    icache_addr = 16'h0A0E; icache_miss = 1'b1;
    exp_wr.push_back({16'h3004, 16'h1357});
    push_block(1'b0, 16'h0A0E, 8, 8);
    tick();
    checks++;
    if ({s_en, s_wr, s_dstall} !== 3'b110) begin
      fails++;
      $display("FAIL store_same_cycle: got en,wr,dstall=%b%b%b required 110", s_en, s_wr, s_dstall);
    end
    dcache_wr = 1'b0;
    tick();
    checks++;
    if ({s_en, s_wr} !== 2'b10) begin
      fails++;
      $display("FAIL ifill_first_read: got en,wr=%b%b required 10", s_en, s_wr);
    end
    for (int c = 2; c < 40 && id_c < 0; c++) begin
      tick();
      if (s_idone) id_c = c;
    end
    icache_miss = 1'b0;
    tick();
    checks++;
    if (id_c != 8 + LAT) begin
      fails++;
      $display("FAIL store_miss_done: got idone@%0d required %0d", id_c, 8 + LAT);
    end
    check_queues_empty("store_miss");
  endtask

  task automatic test_abort;
    int dfwe_n, bad, dd_c;
    dfwe_n = 0; bad = 0; dd_c = -1;
    dcache_addr = 16'h4006; dcache_miss = 1'b1;
    push_block(1'b1, 16'h4006, 7, 3);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (s_dfwe) dfwe_n++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, mem_enable, dcache_fill_we, icache_fill_we, dcache_done} !== 5'b00000
        || dfwe_n != 3) begin
      fails++;
      $display("FAIL abort_immediate: got busy,en,dfwe,ifwe,ddone=%b%b%b%b%b words=%0d required 00000 3",
               busy, mem_enable, dcache_fill_we, icache_fill_we, dcache_done, dfwe_n);
    end
    dcache_miss = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (s_busy || s_en || s_dfwe || s_ddone) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL abort_quiet: got %0d active cycles in reset required 0", bad);
    end
    check_queues_empty("abort");
    rst_n = 1'b1;
    tick();
    dcache_miss = 1'b1;
    push_block(1'b1, 16'h4006, 8, 8);
    for (int c = 0; c < 40 && dd_c < 0; c++) begin
      tick();
      if (s_ddone) dd_c = c;
    end
    dcache_miss = 1'b0;
    tick();
    checks++;
    if (dd_c != 8 + LAT) begin
      fails++;
      $display("FAIL refill_done: got ddone@%0d required %0d", dd_c, 8 + LAT);
    end
    check_queues_empty("refill");
  endtask

  initial begin
    test_reset();
    test_imiss();
    test_simultaneous();
    test_store_during_fill();
    test_store_and_miss();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
